// File: rtl/moving_integrator_ctrl.sv
// moving_integrator_ctrl
// Sequencer and self-trigger controller for one moving-integrator filter
// channel. It steps the filter through reset, a zero-input flush of its
// delay line and a live-input warm-up, then arms a rising-edge threshold
// trigger with a programmable dead time after each pulse.
//
// Optional feature: define MIF_CTRL_TRIG_COUNT_EN to build a saturating
// count of accepted triggers on trig_count. Without it, trig_count is
// tied to zero.
module moving_integrator_ctrl #(
    parameter int FLUSH_LEN   = 34,
    parameter int WARMUP_LEN  = 40,
    parameter int HOLDOFF_LEN = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic signed [15:0] threshold,
    input  logic signed [15:0] filt_y,
    output logic               filt_reset,
    output logic               filt_enable,
    output logic               filt_zero_in,
    output logic               armed,
    output logic               trigger,
    output logic [31:0]        trig_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_FLUSH   = 3'd2,
        S_WARMUP  = 3'd3,
        S_ARMED   = 3'd4,
        S_HOLDOFF = 3'd5
    } state_t;

    // The shared down-counter is loaded with (length - 1) on entry to a
    // timed state; the state is left when the counter reads zero.
    localparam logic [31:0] RST_LOAD     = 32'd1;
    localparam logic [31:0] FLUSH_LOAD   = 32'(FLUSH_LEN - 1);
    localparam logic [31:0] WARMUP_LOAD  = 32'(WARMUP_LEN - 1);
    localparam logic [31:0] HOLDOFF_LOAD = 32'(HOLDOFF_LEN - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        prev_above_q, prev_above_d;
    logic        trigger_q, trigger_d;
    logic        filt_reset_q, filt_reset_d;
    logic        filt_enable_q, filt_enable_d;
    logic        filt_zero_in_q, filt_zero_in_d;
    logic        armed_q, armed_d;
    logic        above;

    // Full 16-bit signed, strict comparison against the live threshold.
    assign above = (filt_y > threshold);

    // Next-state, counter, crossing detection and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prev_above_d = prev_above_q;
        trigger_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d        = '0;
                prev_above_d = 1'b0;
                if (run) begin
                    state_d = S_RST;
                    cnt_d   = RST_LOAD;
                end
            end
            S_RST: begin
                if (cnt_q == '0) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_WARMUP;
                    cnt_d   = WARMUP_LOAD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_WARMUP: begin
                // Track the comparison during warm-up so a signal already
                // above threshold at arming time is not seen as a crossing.
                prev_above_d = above;
                if (cnt_q == '0) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_ARMED: begin
                prev_above_d = above;
                if (above && !prev_above_q) begin
                    trigger_d = 1'b1;
                    state_d   = S_HOLDOFF;
                    cnt_d     = HOLDOFF_LOAD;
                end
            end
            S_HOLDOFF: begin
                prev_above_d = above;
                if (cnt_q == '0) begin
                    state_d = S_ARMED;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Dropping run wins over everything, including a same-cycle crossing.
        if (state_q != S_IDLE && !run) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            prev_above_d = 1'b0;
            trigger_d    = 1'b0;
        end

        // Outputs are decoded from the next state so they are registered
        // alongside the state itself.
        filt_reset_d   = (state_d == S_IDLE) || (state_d == S_RST);
        filt_enable_d  = (state_d == S_FLUSH) || (state_d == S_WARMUP) ||
                         (state_d == S_ARMED) || (state_d == S_HOLDOFF);
        filt_zero_in_d = (state_d == S_IDLE) || (state_d == S_RST) ||
                         (state_d == S_FLUSH);
        armed_d        = (state_d == S_ARMED);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            prev_above_q   <= 1'b0;
            trigger_q      <= 1'b0;
            filt_reset_q   <= 1'b1;
            filt_enable_q  <= 1'b0;
            filt_zero_in_q <= 1'b1;
            armed_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prev_above_q   <= prev_above_d;
            trigger_q      <= trigger_d;
            filt_reset_q   <= filt_reset_d;
            filt_enable_q  <= filt_enable_d;
            filt_zero_in_q <= filt_zero_in_d;
            armed_q        <= armed_d;
        end
    end

    assign filt_reset   = filt_reset_q;
    assign filt_enable  = filt_enable_q;
    assign filt_zero_in = filt_zero_in_q;
    assign armed        = armed_q;
    assign trigger      = trigger_q;

`ifdef MIF_CTRL_TRIG_COUNT_EN
    logic [31:0] trig_count_q, trig_count_d;

    // Saturating trigger count; only reset clears it, run does not.
    always_comb begin
        trig_count_d = trig_count_q;
        if (trigger_d && (trig_count_q != 32'hFFFF_FFFF)) begin
            trig_count_d = trig_count_q + 32'd1;
        end
    end

    // Trigger count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_count_q <= '0;
        end else begin
            trig_count_q <= trig_count_d;
        end
    end

    assign trig_count = trig_count_q;
`else
    assign trig_count = '0;
`endif

endmodule

// File: tb/tb_moving_integrator_ctrl.sv
// Testbench for moving_integrator_ctrl: directed phases with randomized
// filter samples, checked every cycle against a timestamp-based model.
module tb_moving_integrator_ctrl;

    localparam int F = 34;
    localparam int W = 40;
    localparam int H = 256;
`ifdef MIF_CTRL_TRIG_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               run;
    logic signed [15:0] threshold;
    logic signed [15:0] filt_y;
    logic               filt_reset;
    logic               filt_enable;
    logic               filt_zero_in;
    logic               armed;
    logic               trigger;
    logic [31:0]        trig_count;

    moving_integrator_ctrl #(
        .FLUSH_LEN  (F),
        .WARMUP_LEN (W),
        .HOLDOFF_LEN(H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .threshold   (threshold),
        .filt_y      (filt_y),
        .filt_reset  (filt_reset),
        .filt_enable (filt_enable),
        .filt_zero_in(filt_zero_in),
        .armed       (armed),
        .trigger     (trigger),
        .trig_count  (trig_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n     = 0;

    // Reference model: acquisition start time and last trigger time.
    bit          m_running    = 1'b0;
    bit          m_has_trig   = 1'b0;
    bit          m_prev_above = 1'b0;
    int          m_start      = 0;
    int          m_last       = 0;
    bit          exp_reset    = 1'b1;
    bit          exp_enable   = 1'b0;
    bit          exp_zero     = 1'b1;
    bit          exp_armed    = 1'b0;
    bit          exp_trig     = 1'b0;
    logic [31:0] exp_cnt      = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, expv, n);
        end
    endtask

    // One clock: update the model from the sampled inputs, then compare.
    task automatic step();
        bit above;
        int e;
        @(posedge clk);
        n++;
        above = (filt_y > threshold);
        exp_trig = 1'b0;
        if (reset) begin
            m_running    = 1'b0;
            m_has_trig   = 1'b0;
            m_prev_above = 1'b0;
            exp_cnt      = '0;
        end else begin
            if (!run) begin
                m_running = 1'b0;
            end else if (!m_running) begin
                m_running  = 1'b1;
                m_start    = n;
                m_has_trig = 1'b0;
            end else if (exp_armed && above && !m_prev_above) begin
                exp_trig   = 1'b1;
                m_has_trig = 1'b1;
                m_last     = n;
                if (CNT_ON && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
            end
            m_prev_above = above;
        end
        e = n - m_start;
        if (!m_running || e < 2) begin
            {exp_reset, exp_enable, exp_zero, exp_armed} = 4'b1010;
        end else if (e < 2 + F) begin
            {exp_reset, exp_enable, exp_zero, exp_armed} = 4'b0110;
        end else if (e < 2 + F + W) begin
            {exp_reset, exp_enable, exp_zero, exp_armed} = 4'b0100;
        end else begin
            {exp_reset, exp_enable, exp_zero} = 3'b010;
            exp_armed = !(m_has_trig && (n - m_last) < H);
        end
        #1;
        check("filt_reset", 32'(filt_reset), 32'(exp_reset));
        check("filt_enable", 32'(filt_enable), 32'(exp_enable));
        check("filt_zero_in", 32'(filt_zero_in), 32'(exp_zero));
        check("armed", 32'(armed), 32'(exp_armed));
        check("trigger", 32'(trigger), 32'(exp_trig));
        check("trig_count", trig_count, exp_cnt);
    endtask

    int rst_hi, flush_cyc, lat, ntrig, first, t0, last, min_gap;
    bit found;

    initial begin
        reset = 1'b1; run = 1'b0; threshold = 16'sd100; filt_y = 16'sd0;
        repeat (3) step();

        // Start-up sequence timing.
        reset = 1'b0; run = 1'b1;
        rst_hi = int'(filt_reset); flush_cyc = 0; lat = 0;
        for (int i = 0; i < 200 && !armed; i++) begin
            step();
            lat++;
            if (filt_reset) rst_hi++;
            if (filt_enable && filt_zero_in) flush_cyc++;
        end
        check("startup_reset_cycles", 32'(rst_hi), 32'd3);
        check("startup_flush_cycles", 32'(flush_cyc), 32'(F));
        check("startup_latency", 32'(lat), 32'd77);

        // Single step crossing, held above threshold afterwards.
        step();
        filt_y = 16'sd200; t0 = n; ntrig = 0; first = -1;
        repeat (600) begin
            step();
            if (trigger) begin
                ntrig++;
                if (first < 0) first = n;
            end
        end
        check("single_count", 32'(ntrig), 32'd1);
        check("single_latency", 32'(first - t0), 32'd1);
        check("single_trig_count", trig_count, CNT_ON ? 32'd1 : 32'd0);

        // Repeated crossings every 20 cycles.
        ntrig = 0; last = -1; min_gap = 1000000;
        for (int i = 0; i < 1200; i++) begin
            filt_y = (((i / 10) % 2) != 0) ? 16'sd200 : 16'sd0;
            step();
            if (trigger) begin
                if (last >= 0 && (n - last) < min_gap) min_gap = n - last;
                last = n;
                ntrig++;
            end
        end
        check("repeat_enough_triggers", 32'(ntrig >= 3), 32'd1);
        check("repeat_min_spacing", 32'(min_gap >= H + 1), 32'd1);

        // Random samples and occasional threshold changes, incl. extremes.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 49) == 0) threshold = 16'(int'($urandom_range(0, 200)) - 100);
            case ($urandom_range(0, 19))
                0: filt_y = 16'sh7FFF;
                1: filt_y = 16'sh8000;
                default: filt_y = 16'(int'($urandom_range(0, 400)) - 200);
            endcase
            step();
        end

        // Negative threshold.
        threshold = -16'sd50; filt_y = -16'sd100;
        repeat (300) step();
        filt_y = -16'sd10; ntrig = 0;
        repeat (20) begin
            step();
            if (trigger) ntrig++;
        end
        check("neg_threshold_count", 32'(ntrig), 32'd1);

        // Maximum threshold never triggers.
        threshold = 16'sh7FFF; filt_y = -16'sd100;
        repeat (300) step();
        filt_y = 16'sh7FFF; ntrig = 0;
        repeat (300) begin
            step();
            if (trigger) ntrig++;
        end
        check("max_threshold_count", 32'(ntrig), 32'd0);

        // Stop in the same cycle as a crossing.
        threshold = 16'sd100; filt_y = 16'sd0;
        step();
        found = armed;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            found = armed;
        end
        check("stop_precond_armed", 32'(found), 32'd1);
        filt_y = 16'sd200; run = 1'b0;
        step();
        check("stop_no_trigger", 32'(trigger), 32'd0);
        check("stop_enable_low", 32'(filt_enable), 32'd0);
        check("stop_filt_reset", 32'(filt_reset), 32'd1);
        run = 1'b1; filt_y = 16'sd0; lat = 0;
        for (int i = 0; i < 200 && !armed; i++) begin
            step();
            lat++;
        end
        check("restart_latency", 32'(lat), 32'd77);

        // Reset during holdoff.
        filt_y = 16'sd200;
        step();
        found = trigger;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            found = trigger;
        end
        check("holdoff_precond_trigger", 32'(found), 32'd1);
        repeat (10) step();
        check("holdoff_not_armed", 32'(armed), 32'd0);
        reset = 1'b1;
        step();
        check("rst_filt_reset", 32'(filt_reset), 32'd1);
        check("rst_filt_enable", 32'(filt_enable), 32'd0);
        check("rst_filt_zero_in", 32'(filt_zero_in), 32'd1);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_trigger", 32'(trigger), 32'd0);
        check("rst_trig_count", trig_count, 32'd0);
        reset = 1'b0; run = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
